// File: rtl/gmii_rx_pkg.sv
// Shared GMII receive definitions: FSM states, Ethernet CRC-32 constants and
// the byte-wide reflected CRC-32 update used by the RX and TX paths.
package gmii_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_DATA = 2'd2,
      ST_DROP = 2'd3
   } state_e;

   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   // Reflected CRC-32, data consumed LSB first.
   function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if ((c[0] ^ data[i]) == 1'b1) begin
            c = (c >> 1) ^ CRC_POLY;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational next-state of the Ethernet CRC-32 register for one byte.
module eth_crc32_d8
   import gmii_rx_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   assign crc_out = crc32_d8(crc_in, data);

endmodule

// File: rtl/gmii_rx_frame.sv
// GMII receive front end: strips preamble/SFD, checks and removes the FCS, flags bad frames.
// Optional statistics counters are built when GMII_RX_STATS_EN is defined.
module gmii_rx_frame
   import gmii_rx_pkg::*;
#(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1522
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_dv,
   input  logic        rx_er,
   input  logic [7:0]  rx_d,
   output logic        m_valid,
   output logic [7:0]  m_data,
   output logic        m_sof,
   output logic        m_eof,
   output logic        m_err,
   output logic [11:0] m_len
`ifdef GMII_RX_STATS_EN
   ,
   output logic [31:0] stat_ok,
   output logic [31:0] stat_bad,
   output logic [31:0] stat_drop
`endif
);

   localparam logic [11:0] MIN_LEN = 12'(MIN_FRAME);
   localparam logic [11:0] MAX_LEN = 12'(MAX_FRAME);

   state_e          state_q, state_d;
   logic [31:0]     crc_q, crc_d, crc_next_s;
   logic [4:0][7:0] line_q, line_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [11:0]     len_q, len_d;
   logic            err_q, err_d;
   logic            first_q, first_d;
   logic            m_valid_q, m_valid_d;
   logic [7:0]      m_data_q, m_data_d;
   logic            m_sof_q, m_sof_d;
   logic            m_eof_q, m_eof_d;
   logic            m_err_q, m_err_d;
   logic [11:0]     m_len_q, m_len_d;

   eth_crc32_d8 u_crc (
      .crc_in  (crc_q),
      .data    (rx_d),
      .crc_out (crc_next_s)
   );

   // Next-state: frame FSM, 5-byte FCS delay line (newest at [0], oldest at [4]) and output beat.
   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      line_d    = line_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      err_d     = err_q;
      first_d   = first_q;
      m_valid_d = 1'b0;
      m_data_d  = 8'h00;
      m_sof_d   = 1'b0;
      m_eof_d   = 1'b0;
      m_err_d   = 1'b0;
      m_len_d   = 12'd0;
      case (state_q)
         ST_IDLE: begin
            if (rx_dv) begin
               if (rx_d == PREAMBLE_BYTE) begin
                  state_d = ST_PRE;
               end else begin
                  state_d = ST_DROP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PRE: begin
            if (!rx_dv) begin
               state_d = ST_IDLE;
            end else if (rx_d == PREAMBLE_BYTE) begin
               state_d = ST_PRE;
            end else if (rx_d == SFD_BYTE) begin
               state_d = ST_DATA;
               crc_d   = CRC_INIT;
               cnt_d   = 3'd0;
               len_d   = 12'd0;
               err_d   = 1'b0;
               first_d = 1'b1;
            end else begin
               state_d = ST_DROP;
            end
         end
         ST_DATA: begin
            if (rx_dv) begin
               crc_d  = crc_next_s;
               line_d = {line_q[3:0], rx_d};
               err_d  = err_q | rx_er;
               if (len_q != 12'hFFF) begin
                  len_d = len_q + 12'd1;
               end else begin
                  len_d = len_q;
               end
               if (cnt_q == 3'd5) begin
                  m_valid_d = 1'b1;
                  m_data_d  = line_q[4];
                  m_sof_d   = first_q;
                  first_d   = 1'b0;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end else begin
               // dv fell: the four youngest bytes are the FCS and are discarded.
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
               if (cnt_q == 3'd5) begin
                  m_valid_d = 1'b1;
                  m_data_d  = line_q[4];
                  m_sof_d   = first_q;
                  m_eof_d   = 1'b1;
                  m_err_d   = err_q | rx_er | (crc_q != CRC_RESIDUE) |
                              (len_q < MIN_LEN) | (len_q > MAX_LEN);
                  m_len_d   = len_q - 12'd4;
               end else begin
                  m_valid_d = 1'b0;
               end
            end
         end
         ST_DROP: begin
            if (!rx_dv) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DROP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered output beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         crc_q     <= CRC_INIT;
         line_q    <= '0;
         cnt_q     <= 3'd0;
         len_q     <= 12'd0;
         err_q     <= 1'b0;
         first_q   <= 1'b0;
         m_valid_q <= 1'b0;
         m_data_q  <= 8'h00;
         m_sof_q   <= 1'b0;
         m_eof_q   <= 1'b0;
         m_err_q   <= 1'b0;
         m_len_q   <= 12'd0;
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         line_q    <= line_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         err_q     <= err_d;
         first_q   <= first_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_sof_q   <= m_sof_d;
         m_eof_q   <= m_eof_d;
         m_err_q   <= m_err_d;
         m_len_q   <= m_len_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_sof   = m_sof_q;
   assign m_eof   = m_eof_q;
   assign m_err   = m_err_q;
   assign m_len   = m_len_q;

`ifdef GMII_RX_STATS_EN
   logic [31:0] stat_ok_q, stat_ok_d;
   logic [31:0] stat_bad_q, stat_bad_d;
   logic [31:0] stat_drop_q, stat_drop_d;
   logic        drop_evt_s;

   // A drop is any entry into DROP, or a frame that ended before the delay line filled.
   assign drop_evt_s = ((state_q != ST_DROP) && (state_d == ST_DROP)) ||
                       ((state_q == ST_DATA) && !rx_dv && (cnt_q != 3'd5));

   // Counter next-state; ok/bad counted the cycle after the eof beat.
   always_comb begin
      stat_ok_d   = stat_ok_q;
      stat_bad_d  = stat_bad_q;
      stat_drop_d = stat_drop_q;
      if (m_valid_q && m_eof_q) begin
         if (m_err_q) begin
            stat_bad_d = stat_bad_q + 32'd1;
         end else begin
            stat_ok_d = stat_ok_q + 32'd1;
         end
      end else begin
         stat_ok_d = stat_ok_q;
      end
      if (drop_evt_s) begin
         stat_drop_d = stat_drop_q + 32'd1;
      end else begin
         stat_drop_d = stat_drop_q;
      end
   end

   // Statistics counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_ok_q   <= 32'd0;
         stat_bad_q  <= 32'd0;
         stat_drop_q <= 32'd0;
      end else begin
         stat_ok_q   <= stat_ok_d;
         stat_bad_q  <= stat_bad_d;
         stat_drop_q <= stat_drop_d;
      end
   end

   assign stat_ok   = stat_ok_q;
   assign stat_bad  = stat_bad_q;
   assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Randomized scoreboard bench for gmii_rx_frame; frame-level reference model.
module tb_gmii_rx_frame;

   typedef logic [7:0] bq_t[$];

   typedef struct {
      logic [7:0]  data;
      logic        sof;
      logic        eof;
      logic        err;
      logic [11:0] len;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_dv;
   logic        rx_er;
   logic [7:0]  rx_d;
   logic        m_valid;
   logic [7:0]  m_data;
   logic        m_sof;
   logic        m_eof;
   logic        m_err;
   logic [11:0] m_len;
`ifdef GMII_RX_STATS_EN
   logic [31:0] stat_ok;
   logic [31:0] stat_bad;
   logic [31:0] stat_drop;
`endif

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    exp_ok = 0;
   int    exp_bad = 0;
   int    exp_drop = 0;

   gmii_rx_frame dut (
      .clk     (clk),
      .rst     (rst),
      .rx_dv   (rx_dv),
      .rx_er   (rx_er),
      .rx_d    (rx_d),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_sof   (m_sof),
      .m_eof   (m_eof),
      .m_err   (m_err),
      .m_len   (m_len)
`ifdef GMII_RX_STATS_EN
      ,
      .stat_ok   (stat_ok),
      .stat_bad  (stat_bad),
      .stat_drop (stat_drop)
`endif
   );

   always #4 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Ethernet FCS of the first n bytes (CRC-32 over the bytes, complemented).
   function automatic logic [31:0] fcs_of(input bq_t f, input int n);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 8; b++) begin
            if ((c[0] ^ f[i][b]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
            else c = c >> 1;
         end
      end
      return ~c;
   endfunction

   function automatic void add_fcs(inout bq_t f);
      logic [31:0] fcs;
      fcs = fcs_of(f, f.size());
      f.push_back(fcs[7:0]);
      f.push_back(fcs[15:8]);
      f.push_back(fcs[23:16]);
      f.push_back(fcs[31:24]);
   endfunction

   function automatic void mk_frame(input int n, output bq_t f);
      f = {};
      if (n <= 4) begin
         for (int i = 0; i < n; i++) f.push_back(8'($urandom_range(0, 255)));
      end else begin
         for (int i = 0; i < n - 4; i++) f.push_back(8'($urandom_range(0, 255)));
         add_fcs(f);
      end
   endfunction

   function automatic void mk_pre(input int n55, output bq_t p);
      p = {};
      for (int i = 0; i < n55; i++) p.push_back(8'h55);
      p.push_back(8'hD5);
   endfunction

   // Reference model: expected beats and counter effects of one frame.
   function automatic void expect_frame(input bq_t pre, input bq_t f, input bit er);
      bit          pre_ok;
      bit          crc_ok;
      bit          bad;
      int          n;
      logic [31:0] fcs;
      beat_t       bt;
      n = f.size();
      pre_ok = (pre.size() >= 2) && (pre[pre.size()-1] == 8'hD5);
      for (int i = 0; i < pre.size() - 1; i++) if (pre[i] != 8'h55) pre_ok = 1'b0;
      if (!pre_ok || n <= 4) begin
         exp_drop++;
         return;
      end
      fcs = fcs_of(f, n - 4);
      crc_ok = (fcs == {f[n-1], f[n-2], f[n-3], f[n-4]});
      bad = !crc_ok || er || (n < 64) || (n > 1522);
      for (int k = 0; k <= n - 5; k++) begin
         bt.data = f[k];
         bt.sof  = (k == 0);
         bt.eof  = (k == n - 5);
         bt.err  = bt.eof ? bad : 1'b0;
         bt.len  = bt.eof ? 12'(((n > 4095) ? 4095 : n) - 4) : 12'd0;
         exp_q.push_back(bt);
      end
      if (bad) exp_bad++;
      else exp_ok++;
   endfunction

   task automatic drive_byte(input logic [7:0] b, input logic er);
      @(posedge clk);
      #1;
      rx_dv = 1'b1;
      rx_d  = b;
      rx_er = er;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rx_dv = 1'b0;
         rx_d  = 8'h00;
         rx_er = 1'b0;
      end
   endtask

   task automatic send_frame(input bq_t pre, input bq_t f, input int er_idx, input int gap);
      expect_frame(pre, f, (er_idx >= 0) && (er_idx < f.size()));
      foreach (pre[i]) drive_byte(pre[i], 1'b0);
      foreach (f[i]) drive_byte(f[i], i == er_idx);
      idle(gap);
   endtask

   // Reset while byte rst_idx is on the bus; beats emitted before it survive, then DROP.
   task automatic send_reset_frame(input bq_t pre, input bq_t f, input int rst_idx, input int gap);
      beat_t bt;
      for (int k = 0; k <= rst_idx - 7; k++) begin
         bt.data = f[k];
         bt.sof  = (k == 0);
         bt.eof  = 1'b0;
         bt.err  = 1'b0;
         bt.len  = 12'd0;
         exp_q.push_back(bt);
      end
      exp_ok   = 0;
      exp_bad  = 0;
      exp_drop = 1;
      foreach (pre[i]) drive_byte(pre[i], 1'b0);
      foreach (f[i]) begin
         drive_byte(f[i], 1'b0);
         if (i == rst_idx) rst = 1'b1;
         if (i == rst_idx + 2) rst = 1'b0;
      end
      idle(gap);
   endtask

   // Monitor: every presented beat is popped and compared against the scoreboard.
   always @(negedge clk) begin
      beat_t e;
      if (!rst && m_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got data=%h sof=%b eof=%b, expected no beat", m_data, m_sof, m_eof);
         end else begin
            e = exp_q.pop_front();
            if (m_data !== e.data || m_sof !== e.sof || m_eof !== e.eof ||
                (e.eof && (m_err !== e.err || m_len !== e.len))) begin
               errors++;
               $display("FAIL beat: got data=%h sof=%b eof=%b err=%b len=%0d, expected data=%h sof=%b eof=%b err=%b len=%0d",
                        m_data, m_sof, m_eof, m_err, m_len, e.data, e.sof, e.eof, e.err, e.len);
            end
         end
      end
   end

   initial begin
      bq_t pre, pre7, ref_f, f;
      int  n;
      rst   = 1'b1;
      rx_dv = 1'b0;
      rx_er = 1'b0;
      rx_d  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_m_valid", 32'(m_valid), 32'd0);
      chk("reset_m_data", 32'(m_data), 32'd0);
      chk("reset_m_sof", 32'(m_sof), 32'd0);
      chk("reset_m_eof", 32'(m_eof), 32'd0);
      chk("reset_m_err", 32'(m_err), 32'd0);
      chk("reset_m_len", 32'(m_len), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // Reference 64-byte UDP write frame.
      ref_f = '{8'h00, 8'h80, 8'h55, 8'hEC, 8'h00, 8'h6B, 8'h00, 8'h0A, 8'h35, 8'h00, 8'h01, 8'h02,
                8'h08, 8'h00, 8'h45, 8'h00, 8'h00, 8'h2E, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'h02, 8'h07, 8'hD0,
                8'h07, 8'hD0, 8'h00, 8'h1A, 8'h00, 8'h00};
      for (int i = 0; i < 17; i++) ref_f.push_back(8'(i + 1));
      ref_f.push_back(8'h00);
      add_fcs(ref_f);
      mk_pre(7, pre7);

      send_frame(pre7, ref_f, -1, 2);
      f = ref_f;
      f[45] = f[45] ^ 8'h01;
      send_frame(pre7, f, -1, 2);
      send_frame(pre7, ref_f, 40, 1);
      send_frame(pre7, ref_f, -1, 2);

      mk_frame(40, f);
      send_frame(pre7, f, -1, 2);
      mk_frame(3, f);
      send_frame(pre7, f, -1, 2);

      pre = '{8'h55, 8'h55, 8'hAA, 8'hD5};
      send_frame(pre, ref_f, -1, 2);
      pre = '{8'hD5};
      send_frame(pre, ref_f, -1, 2);
      mk_pre(3, pre);
      send_frame(pre, ref_f, -1, 2);
      mk_pre(1, pre);
      send_frame(pre, ref_f, -1, 1);

      // Length boundaries.
      mk_frame(5, f);    send_frame(pre7, f, -1, 1);
      mk_frame(4, f);    send_frame(pre7, f, -1, 1);
      mk_frame(63, f);   send_frame(pre7, f, -1, 1);
      mk_frame(64, f);   send_frame(pre7, f, -1, 1);
      mk_frame(1522, f); send_frame(pre7, f, -1, 1);
      mk_frame(1523, f); send_frame(pre7, f, -1, 2);

      for (int t = 0; t < 24; t++) begin
         n = $urandom_range(0, 9) == 0 ? $urandom_range(1, 4) : $urandom_range(5, 200);
         mk_frame(n, f);
         if (n > 4 && $urandom_range(0, 3) == 0) begin
            int idx;
            idx = $urandom_range(0, n - 1);
            f[idx] = f[idx] ^ 8'(1 << $urandom_range(0, 7));
         end
         mk_pre($urandom_range(1, 7), pre);
         send_frame(pre, f, ($urandom_range(0, 9) == 0) ? $urandom_range(0, n - 1) : -1,
                    $urandom_range(1, 3));
      end

      send_reset_frame(pre7, ref_f, 30, 2);
      send_frame(pre7, ref_f, -1, 2);

      idle(10);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
`ifdef GMII_RX_STATS_EN
      chk("stat_ok", stat_ok, 32'(exp_ok));
      chk("stat_bad", stat_bad, 32'(exp_bad));
      chk("stat_drop", stat_drop, 32'(exp_drop));
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
